muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit that extends the combinational ALU with the RV32M operation set. It accepts one operation at a time over a valid/ready handshake and computes divides and remainders iteratively, one quotient bit per cycle. It returns the result over a second valid/ready handshake. It sits beside the ALU in the execute stage, and the pipeline stalls on `in_ready`.

## Interface
- `XLEN`, default 32: operand and result width, ≥ 8, even.
- `clk` in, 1: rising-edge clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `flush` in, 1: synchronous kill of the in-flight operation.
- `in_valid` in, 1: request valid.
- `in_ready` out, 1: unit can accept a request this cycle.
- `op` in, `md_op_t`: one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `a` in, XLEN: operand A (rs1).
- `b` in, XLEN: operand B (rs2).
- `out_valid` out, 1: result valid.
- `out_ready` in, 1: consumer accepts the result.
- `y` out, XLEN: result.
- `div_zero` out, 1: result came from a DIV/DIVU/REM/REMU with b == 0. Qualified by `out_valid`.
- `busy` out, 1: state ≠ IDLE.

## Operation
- States are IDLE, CALC and DONE.
- IDLE → CALC: `in_valid && in_ready`. Operands and `op` are latched.
- IDLE → DONE: same accept condition, for special cases only (below).
- CALC → DONE: when the iteration counter reaches XLEN-1.
- DONE → IDLE: `out_ready`, with no new accept.
- DONE → CALC or DONE: `out_ready && in_valid` in the same cycle. This is back-to-back operation.
- `in_ready` = (state == IDLE) || (state == DONE && out_ready).
- Signed ops convert to magnitudes at accept. The result sign is applied when entering DONE.
- MULHSU: `a` is signed, `b` is unsigned.
- MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits of the 2·XLEN product.
- Iterative multiply is shift-add, 1 bit per cycle, XLEN cycles.
- Divide is restoring, 1 bit per cycle, XLEN cycles. Quotient and remainder are both kept internally.
- Special cases skip CALC (1-cycle):
  - b == 0: DIV and DIVU give all-ones. REM and REMU give `a`. `div_zero` = 1.
  - DIV with a = MIN_SIGNED, b = -1: gives MIN_SIGNED. REM gives 0. `div_zero` = 0.
- `y` and `div_zero` are registered and held stable while `out_valid && !out_ready`.
- `flush`: next state is IDLE from any state. The pending result is dropped and `out_valid` goes low the next cycle.
  - `flush` overrides a simultaneous `in_valid`: nothing is accepted that cycle.
- New inputs presented while the unit is not ready are ignored. The requester must hold them.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `busy` 0, `y` 0, `div_zero` 0, counter 0.
- Reset asserted mid-operation aborts immediately and asynchronously.
- Latency is counted from the accept edge to the first cycle with `out_valid` high:
  - Iterative op: XLEN+1 cycles (33 at XLEN=32).
  - Special case: 1 cycle.
- Throughput: one op per latency cycles when `out_ready` is held high.
- No combinational path from `in_valid` to `out_valid`.
- `in_ready` depends combinationally on `out_ready` only.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - All four MUL ops use a single-cycle 2·XLEN-bit multiplier, registered into DONE. Latency is 1 cycle.
  - Divide ops are unchanged.
- `MULDIV_FAST_MUL_EN` undefined:
  - MUL ops use the iterative shift-add path. Latency is XLEN+1 cycles.
  - No hardware multiplier is inferred.
- The interface is identical in both builds.

## Structure
- Add `md_op_t` (3-bit enum, 8 ops) to the shared `alu_pkg`, next to `alu_op_t`.
- Add the state enum `md_state_t` to `alu_pkg`.
- Add the helper constants `MD_IS_DIV`, `MD_IS_REM` and `MD_IS_SIGNED_A`/`MD_IS_SIGNED_B` to `alu_pkg`.
- One sub-module, `muldiv_div_core`, is natural: the restoring divider step logic, parametrised on XLEN, returning quotient and remainder. Sign fix-up, special cases and the FSM stay in `muldiv_unit`.

## Test plan
- DIV a=7, b=-2 (0xFFFFFFFE) → `y`=0xFFFFFFFD after 33 cycles. REM with the same operands → `y`=1. DIVU a=100, b=7 → 14. REMU with the same operands → 2.
- DIVU a=0x1234, b=0 → `y`=0xFFFFFFFF, `div_zero`=1, 1-cycle latency. REMU with the same operands → `y`=0x1234.
- DIV a=0x80000000, b=0xFFFFFFFF → `y`=0x80000000, `div_zero`=0. REM with the same operands → `y`=0.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MUL 6×7 → 42. Run in both macro builds and check the latency: 1 with the macro defined, 33 without.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after `out_valid` → `y` stays stable and `in_ready`=0.
  - Raise `out_ready` together with a new `in_valid` → new op accepted that cycle, with no bubble.
- Pulse `flush` at cycle 10 of a DIV → `out_valid` never rises and the unit returns to IDLE the next cycle. Assert `rst_n`=0 mid-CALC → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared execute-stage encodings: ALU ops, RV32M mul/div ops and their helper masks
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // One bit per md_op_t value, indexed by the op encoding.
  localparam logic [7:0] MD_IS_DIV      = 8'b1111_0000;
  localparam logic [7:0] MD_IS_REM      = 8'b1100_0000;
  localparam logic [7:0] MD_IS_SIGNED_A = 8'b0101_0110;
  localparam logic [7:0] MD_IS_SIGNED_B = 8'b0101_0010;

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - one restoring-division step on unsigned magnitudes
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // quo_in holds the not-yet-consumed dividend bits; its MSB feeds the partial remainder.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[XLEN]) begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end else begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide unit with valid/ready in and out
// MULDIV_FAST_MUL_EN: single-cycle multiplier for the four MUL ops; divides stay iterative.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            div_zero,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state;
  logic [CNT_W-1:0] cnt;
  md_op_t          op_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opnd;

  logic            accept;
  logic            sa, sb, is_div, is_rem, neg_in;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, sp_y;

  assign in_ready  = (state == MD_IDLE) || (state == MD_DONE && out_ready);
  assign out_valid = (state == MD_DONE);
  assign busy      = (state != MD_IDLE);
  assign accept    = in_valid && in_ready && !flush;

  // Operand decode at accept: magnitudes, result sign and the single-cycle special cases.
  always_comb begin
    is_div  = MD_IS_DIV[op];
    is_rem  = MD_IS_REM[op];
    sa      = MD_IS_SIGNED_A[op] & a[XLEN-1];
    sb      = MD_IS_SIGNED_B[op] & b[XLEN-1];
    a_mag   = sa ? -a : a;
    b_mag   = sb ? -b : b;
    neg_in  = is_rem ? sa : (sa ^ sb);
    b_zero  = (b == '0);
    ovf     = (op == MD_DIV || op == MD_REM) && (a == MIN_SIGNED) && (b == '1);
    special = is_div && (b_zero || ovf);
    if (b_zero) sp_y = is_rem ? a : '1;
    else        sp_y = is_rem ? '0 : MIN_SIGNED;
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
  logic [XLEN-1:0]   div_rem_n, div_quo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_res, fin_y;

  // Shift-add: acc_lo holds the multiplier, product bits shift in from the top.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + ({(XLEN+1){acc_lo[0]}} & {1'b0, opnd});
    mul_hi_n = mul_sum[XLEN:1];
    mul_lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .rem_in  (acc_hi),
    .quo_in  (acc_lo),
    .divisor (opnd),
    .rem_out (div_rem_n),
    .quo_out (div_quo_n)
  );

  // Sign fix-up applied to the final step's output as the result is registered.
  always_comb begin
    prod    = {mul_hi_n, mul_lo_n};
    prod_s  = neg_q ? -prod : prod;
    div_res = MD_IS_REM[op_q] ? div_rem_n : div_quo_n;
    if (MD_IS_DIV[op_q])      fin_y = neg_q ? -div_res : div_res;
    else if (op_q == MD_MUL)  fin_y = prod_s[XLEN-1:0];
    else                      fin_y = prod_s[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_y;

  always_comb begin
    fast_a    = {{XLEN{sa}}, a};
    fast_b    = {{XLEN{sb}}, b};
    fast_prod = fast_a * fast_b;
    fast_y    = (op == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      y        <= '0;
      div_zero <= 1'b0;
    end else if (flush) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_CALC: begin
          acc_hi <= MD_IS_DIV[op_q] ? div_rem_n : mul_hi_n;
          acc_lo <= MD_IS_DIV[op_q] ? div_quo_n : mul_lo_n;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN-1)) begin
            state    <= MD_DONE;
            y        <= fin_y;
            div_zero <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            op_q  <= op;
            neg_q <= neg_in;
            cnt   <= '0;
            if (special) begin
              state    <= MD_DONE;
              y        <= sp_y;
              div_zero <= b_zero;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              state    <= MD_DONE;
              y        <= fast_y;
              div_zero <= 1'b0;
            end
`endif
            else begin
              state  <= MD_CALC;
              acc_hi <= '0;
              acc_lo <= is_div ? a_mag : b_mag;
              opnd   <= is_div ? b_mag : a_mag;
            end
          end else if (state == MD_DONE && out_ready) begin
            state <= MD_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import alu_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  md_op_t          op = MD_MUL;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] y;
  logic            div_zero;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input md_op_t o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    op       = o;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    expect_eq({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input md_op_t o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ey, input logic edz, input int elat);
    int lat;
    issue(tag, o, va, vb);
    wait_out(lat);
    expect_eq({tag, " y"}, y, ey);
    expect_eq({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    expect_eq({tag, " latency"}, lat, elat);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  seen;

    repeat (3) @(negedge clk);
    expect_eq("rst in_ready",  {31'd0, in_ready},  32'd1);
    expect_eq("rst out_valid", {31'd0, out_valid}, 32'd0);
    expect_eq("rst busy",      {31'd0, busy},      32'd0);
    expect_eq("rst y",         y,                  32'd0);
    expect_eq("rst div_zero",  {31'd0, div_zero},  32'd0);
    rst_n = 1'b1;

    run_op("div 7/-2",      MD_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, DIV_LAT);
    run_op("rem 7/-2",      MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0, DIV_LAT);
    run_op("divu 100/7",    MD_DIVU,   32'd100,        32'd7,         32'd14,        1'b0, DIV_LAT);
    run_op("remu 100/7",    MD_REMU,   32'd100,        32'd7,         32'd2,         1'b0, DIV_LAT);
    run_op("div -100/7",    MD_DIV,    32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, DIV_LAT);
    run_op("rem -100/7",    MD_REM,    32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 1'b0, DIV_LAT);
    run_op("divu by0",      MD_DIVU,   32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b1, 1);
    run_op("remu by0",      MD_REMU,   32'h0000_1234,  32'd0,         32'h0000_1234, 1'b1, 1);
    run_op("div ovf",       MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run_op("rem ovf",       MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1);
    run_op("mulh min*min",  MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, MUL_LAT);
    run_op("mulhu ff*ff",   MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT);
    run_op("mulhsu ff*ff",  MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MUL_LAT);
    run_op("mul 6*7",       MD_MUL,    32'd6,          32'd7,         32'd42,        1'b0, MUL_LAT);
    run_op("mul -3*5",      MD_MUL,    32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFF1, 1'b0, MUL_LAT);

    // Backpressure: result held, then back-to-back accept on the releasing cycle.
    issue("bp divu", MD_DIVU, 32'd100, 32'd7);
    wait_out(lat);
    expect_eq("bp first y", y, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_eq("bp held y",        y,                  32'd14);
      expect_eq("bp held in_ready", {31'd0, in_ready},  32'd0);
      expect_eq("bp held valid",    {31'd0, out_valid}, 32'd1);
    end
    op        = MD_REMU;
    a         = 32'd100;
    b         = 32'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 expect_eq("b2b in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end
    wait_out(lat);
    expect_eq("b2b remu y",  y,   32'd2);
    expect_eq("b2b latency", lat, DIV_LAT);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Flush mid-divide: no result, back to idle.
    issue("flush div", MD_DIV, 32'd7, 32'hFFFF_FFFE);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    expect_eq("flush busy",      {31'd0, busy},      32'd0);
    expect_eq("flush in_ready",  {31'd0, in_ready},  32'd1);
    expect_eq("flush out_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    expect_eq("flush no result", {31'd0, seen}, 32'd0);

    // Flush wins over a simultaneous request.
    @(negedge clk);
    op       = MD_DIVU;
    a        = 32'd100;
    b        = 32'd7;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1 begin
      in_valid = 1'b0;
      flush    = 1'b0;
    end
    @(negedge clk);
    expect_eq("flush vs in busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-CALC; y holds 2 from the earlier REMU.
    issue("rst divu", MD_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_eq("arst in_ready",  {31'd0, in_ready},  32'd1);
    expect_eq("arst out_valid", {31'd0, out_valid}, 32'd0);
    expect_eq("arst busy",      {31'd0, busy},      32'd0);
    expect_eq("arst y",         y,                  32'd0);
    expect_eq("arst div_zero",  {31'd0, div_zero},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-rst divu", MD_DIVU, 32'd1000, 32'd33, 32'd30, 1'b0, DIV_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
